// File: rtl/pmu_wake_ctrl_if.sv
// SFR bus between the 8051 core (master) and pmu_wake_ctrl (slave).
interface pmu_wake_ctrl_if;
  logic [7:0] sfrdatai;
  logic [6:0] sfraddr;
  logic       sfrwe;
  logic [7:0] sfrdatao;

  modport master (output sfrdatai, sfraddr, sfrwe, input sfrdatao);
  modport slave  (input sfrdatai, sfraddr, sfrwe, output sfrdatao);
endinterface

// File: rtl/pmu_wake_ctrl.sv
// Power management unit: maskable wake sources, RUN/IDLE/STOP/WARM clock gating, reset stretcher.
// Optional WAKESTAT capture register enabled by defining PMU_WAKE_STATUS_EN.
module pmu_wake_ctrl #(
  parameter int unsigned NUM_WAKE    = 4,
  parameter int unsigned WAKE_DLY    = 16,
  parameter int unsigned RST_STRETCH = 8,
  parameter logic [6:0]  PCON_ADDR   = 7'h07,
  parameter logic [6:0]  WAKEEN_ADDR = 7'h5F
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                reset,
  input  logic                scan_mode,
  input  logic                wdts,
  input  logic                intreq,
  input  logic [NUM_WAKE-1:0] wake_req,
  pmu_wake_ctrl_if.slave      sfr,
  output logic                clkcpu,
  output logic                clkper,
  output logic                rsto,
  output logic                mempsrdrst,
  output logic                stoppmu,
  output logic [1:0]          pmu_state
);

  typedef enum logic [1:0] {RUN = 2'd0, IDLE = 2'd1, STOP = 2'd2, WARM = 2'd3} state_t;

  state_t              state, state_nxt;
  logic [7:0]          settle_cnt, settle_nxt;
  logic [5:0]          pcon_hi;
  logic [NUM_WAKE-1:0] wakeen;
  logic [NUM_WAKE-1:0] wake_masked;
  logic                wake_q;
  logic                cpu_gate, per_gate;
  logic                pcon_we, wakeen_we;

  assign pcon_we     = sfr.sfrwe && (sfr.sfraddr == PCON_ADDR);
  assign wakeen_we   = sfr.sfrwe && (sfr.sfraddr == WAKEEN_ADDR);
  assign wake_masked = wake_req & wakeen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcon_hi <= '0;
      wakeen  <= '0;
      wake_q  <= 1'b0;
    end else begin
      if (pcon_we)   pcon_hi <= sfr.sfrdatai[7:2];
      if (wakeen_we) wakeen  <= sfr.sfrdatai[NUM_WAKE-1:0];
      wake_q <= intreq | (|wake_masked);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      settle_cnt <= '0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    unique case (state)
      RUN: begin
        if (pcon_we && !wake_q) begin
          if (sfr.sfrdatai[1])      state_nxt = STOP;
          else if (sfr.sfrdatai[0]) state_nxt = IDLE;
        end
      end
      IDLE: if (wake_q) state_nxt = RUN;
      STOP: begin
        if (wake_q) begin
          state_nxt  = WARM;
          settle_nxt = 8'(WAKE_DLY - 1);
        end
      end
      WARM: begin
        if (settle_cnt == '0) state_nxt = RUN;
        else                  settle_nxt = settle_cnt - 8'd1;
      end
    endcase
  end

  assign pmu_state = state;
  assign stoppmu   = (state == STOP) || (state == WARM);

  // Gates follow the state about to be entered and change only while clk is low.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      cpu_gate <= 1'b1;
      per_gate <= 1'b1;
    end else begin
      cpu_gate <= (state_nxt == RUN);
      per_gate <= (state_nxt == RUN) || (state_nxt == IDLE);
    end
  end

  assign clkcpu = clk & (cpu_gate | scan_mode);
  assign clkper = clk & (per_gate | scan_mode);

`ifdef PMU_WAKE_STATUS_EN
  logic [7:0] wakestat;
  logic [8:0] wake_snap;

  always_comb begin
    wake_snap                 = '0;
    wake_snap[NUM_WAKE-1:0]   = wake_masked;
    wake_snap[NUM_WAKE]       = intreq;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wakestat <= '0;
    end else if (wake_q && (state == IDLE || state == STOP)) begin
      wakestat <= wake_snap[7:0];
    end else if (sfr.sfrwe && (sfr.sfraddr == 7'(WAKEEN_ADDR + 7'd1))) begin
      wakestat <= '0;
    end
  end
`endif

  always_comb begin
    sfr.sfrdatao = '0;
    if (sfr.sfraddr == PCON_ADDR) begin
      sfr.sfrdatao = {pcon_hi, 2'b00};
    end else if (sfr.sfraddr == WAKEEN_ADDR) begin
      sfr.sfrdatao[NUM_WAKE-1:0] = wakeen;
`ifdef PMU_WAKE_STATUS_EN
    end else if (sfr.sfraddr == 7'(WAKEEN_ADDR + 7'd1)) begin
      sfr.sfrdatao = wakestat;
`endif
    end
  end

  // Reset generator: its flops are set by the reset pin, not by rst.
  logic [1:0] rst_sync;
  logic       wdts_ff;
  logic [7:0] stretch_cnt;
  logic       rst_cause, rst_int, rsto_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rst_sync <= 2'b11;
    else       rst_sync <= {rst_sync[0], 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wdts_ff <= 1'b0;
    else     wdts_ff <= wdts;
  end

  assign rst_cause = rst_sync[1] | (wdts & ~wdts_ff);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   stretch_cnt <= 8'(RST_STRETCH);
    else if (rst_cause)          stretch_cnt <= 8'(RST_STRETCH);
    else if (stretch_cnt != '0)  stretch_cnt <= stretch_cnt - 8'd1;
  end

  assign rst_int    = rst_cause | (stretch_cnt != '0);
  assign mempsrdrst = rst_int;

  always_ff @(negedge clk or posedge reset) begin
    if (reset) rsto_q <= 1'b1;
    else       rsto_q <= rst_int;
  end

  assign rsto = scan_mode ? reset : rsto_q;

endmodule

// File: tb/tb_pmu_wake_ctrl.sv
// Directed self-checking bench for pmu_wake_ctrl with hand-computed expectations.
module tb_pmu_wake_ctrl;
  localparam logic [6:0] PCON   = 7'h07;
  localparam logic [6:0] WAKEEN = 7'h5F;

  logic       clk = 1'b0;
  logic       rst, reset, scan_mode, wdts, intreq;
  logic [3:0] wake_req;
  logic       clkcpu, clkper, rsto, mempsrdrst, stoppmu;
  logic [1:0] pmu_state;
  int         n_checks = 0;
  int         n_errors = 0;
  int         cnt_a, cnt_b;

  pmu_wake_ctrl_if sfr ();

  pmu_wake_ctrl #(
    .NUM_WAKE(4), .WAKE_DLY(16), .RST_STRETCH(8),
    .PCON_ADDR(7'h07), .WAKEEN_ADDR(7'h5F)
  ) dut (
    .clk(clk), .rst(rst), .reset(reset), .scan_mode(scan_mode), .wdts(wdts),
    .intreq(intreq), .wake_req(wake_req), .sfr(sfr),
    .clkcpu(clkcpu), .clkper(clkper), .rsto(rsto), .mempsrdrst(mempsrdrst),
    .stoppmu(stoppmu), .pmu_state(pmu_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sfr_write(input logic [6:0] addr, input logic [7:0] data);
    sfr.sfraddr  = addr;
    sfr.sfrdatai = data;
    sfr.sfrwe    = 1'b1;
    step();
    sfr.sfrwe    = 1'b0;
  endtask

  task automatic sfr_read_check(input string tag, input logic [6:0] addr, input logic [7:0] exp);
    sfr.sfraddr = addr;
    #1;
    check(tag, 32'(sfr.sfrdatao), 32'(exp));
  endtask

  // Counts reset-output high samples over 14 falling edges.
  task automatic count_rst_window();
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      #1;
      if (mempsrdrst) cnt_a++;
      if (rsto)       cnt_b++;
    end
    step();
  endtask

  initial begin
    rst = 1'b1; reset = 1'b1; scan_mode = 1'b0; wdts = 1'b0; intreq = 1'b0;
    wake_req = '0; sfr.sfrwe = 1'b0; sfr.sfraddr = '0; sfr.sfrdatai = '0;
    step();
    step();
    rst = 1'b0;
    check("reset_state", 32'(pmu_state), 32'd0);
    check("reset_stoppmu", 32'(stoppmu), 32'd0);
    check("reset_dout", 32'(sfr.sfrdatao), 32'd0);
    for (int i = 0; i < 3; i++) step();
    reset = 1'b0;
    count_rst_window();
    check("reset_mempsrdrst_len", 32'(cnt_a), 32'd10);
    check("reset_rsto_len", 32'(cnt_b), 32'd10);
    check("run_clkcpu_high", 32'(clkcpu), 32'd1);
    check("run_clkper_high", 32'(clkper), 32'd1);
    @(negedge clk); #1;
    check("run_clkcpu_low", 32'(clkcpu), 32'd0);
    step();

    // Register readback
    sfr_write(PCON, 8'hA8);
    sfr_read_check("pcon_rd", PCON, 8'hA8);
    check("pcon_no_trigger", 32'(pmu_state), 32'd0);
    sfr_write(WAKEEN, 8'hFF);
    sfr_read_check("wakeen_rd", WAKEEN, 8'h0F);
    sfr_read_check("other_rd", 7'h10, 8'h00);
`ifndef PMU_WAKE_STATUS_EN
    sfr_read_check("wakestat_absent", 7'h60, 8'h00);
`endif
    sfr_write(PCON, 8'h00);

    // Idle with wake_req[2]
    sfr_write(WAKEEN, 8'h04);
    sfr_write(PCON, 8'h01);
    check("idle_state", 32'(pmu_state), 32'd1);
    check("idle_clkcpu", 32'(clkcpu), 32'd0);
    check("idle_clkper", 32'(clkper), 32'd1);
    sfr_read_check("pcon_idl_rd0", PCON, 8'h00);
    wake_req = 4'b0100;
    step();
    check("idle_wake_latency", 32'(pmu_state), 32'd1);
    step();
    check("idle_exit", 32'(pmu_state), 32'd0);
    check("idle_exit_clkcpu", 32'(clkcpu), 32'd1);
`ifdef PMU_WAKE_STATUS_EN
    sfr_read_check("wakestat_idle", 7'h60, 8'h04);
    sfr_write(7'h60, 8'h00);
    sfr_read_check("wakestat_clear", 7'h60, 8'h00);
`endif
    wake_req = '0;
    step();
    step();

    // Stop then warm for WAKE_DLY cycles
    sfr_write(PCON, 8'h03);
    check("stop_state", 32'(pmu_state), 32'd2);
    check("stop_stoppmu", 32'(stoppmu), 32'd1);
    check("stop_clkcpu", 32'(clkcpu), 32'd0);
    check("stop_clkper", 32'(clkper), 32'd0);
    scan_mode = 1'b1;
    #1;
    check("scan_clkcpu", 32'(clkcpu), 32'd1);
    scan_mode = 1'b0;
    #1;
    intreq = 1'b1;
    step();
    check("stop_wake_latency", 32'(pmu_state), 32'd2);
    step();
    check("warm_entry", 32'(pmu_state), 32'd3);
    check("warm_clkper", 32'(clkper), 32'd0);
    cnt_a = 0;
    for (int i = 0; i < 30 && pmu_state == 2'd3; i++) begin
      cnt_a++;
      step();
    end
    check("warm_len", 32'(cnt_a), 32'd16);
    check("warm_exit", 32'(pmu_state), 32'd0);
    check("warm_exit_stoppmu", 32'(stoppmu), 32'd0);
    intreq = 1'b0;
    step();
    step();

    // Masked wake in IDLE
    sfr_write(WAKEEN, 8'h00);
    sfr_write(PCON, 8'h01);
    wake_req = 4'hF;
    for (int i = 0; i < 3; i++) step();
    check("masked_stay_idle", 32'(pmu_state), 32'd1);
    sfr_write(WAKEEN, 8'h01);
    check("unmask_t1", 32'(pmu_state), 32'd1);
    step();
    check("unmask_t2", 32'(pmu_state), 32'd1);
    step();
    check("unmask_run", 32'(pmu_state), 32'd0);
    wake_req = '0;
    step();
    step();

    // Entry suppressed by pending wake
    intreq = 1'b1;
    step();
    sfr_write(PCON, 8'h02);
    check("suppress_state", 32'(pmu_state), 32'd0);
    check("suppress_clkcpu", 32'(clkcpu), 32'd1);
    step();
    check("suppress_hold", 32'(pmu_state), 32'd0);
    check("suppress_clkper", 32'(clkper), 32'd1);
    intreq = 1'b0;
    step();
    step();

    // Watchdog stretch, held high gives one pulse
    wdts = 1'b1;
    count_rst_window();
    check("wdt_mempsrdrst_len", 32'(cnt_a), 32'd9);
    check("wdt_rsto_len", 32'(cnt_b), 32'd9);
    count_rst_window();
    check("wdt_held_no_repeat", 32'(cnt_a + cnt_b), 32'd0);
    wdts = 1'b0;
    step();

    // Async rst during WARM
    sfr_write(PCON, 8'h02);
    intreq = 1'b1;
    step();
    step();
    step();
    check("warm_before_rst", 32'(pmu_state), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_state", 32'(pmu_state), 32'd0);
    check("async_rst_stoppmu", 32'(stoppmu), 32'd0);
    intreq = 1'b0;
    step();
    rst = 1'b0;
    step();
    check("after_rst_run", 32'(pmu_state), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/pmu_wake_ctrl.md
Name: pmu_wake_ctrl

Overview:
Parametrised power management unit for the 8051 core family. It generalises the single-wake CPU/peripheral clock gating into NUM_WAKE maskable wake sources and a four-state RUN/IDLE/STOP/WARM machine. STOP exit is followed by a programmable oscillator settle delay. It also stretches both the external and the watchdog reset. It sits between the global clock and the CPU/peripheral clock trees and is programmed through the SFR bus.

Parameters:
NUM_WAKE, 4, number of wake sources (1..8)
WAKE_DLY, 16, clkper-off cycles spent in WARM after STOP exit (1..255)
RST_STRETCH, 8, cycles rsto stays high after a reset cause ends (1..255)
PCON_ADDR, 7'h07, SFR address of the power control register
WAKEEN_ADDR, 7'h5F, SFR address of the wake enable register

Ports:
clk  in  1  global clock
rst  in  1  internal reset, asynchronous, active-high
reset  in  1  hardware reset pin, asynchronous, active-high
scan_mode  in  1  DFT mode
wdts  in  1  watchdog status flag
intreq  in  1  interrupt request from ISR, always enabled as a wake source
wake_req  in  NUM_WAKE  level-high wake requests
sfrdatai  in  8  SFR write data
sfraddr  in  7  SFR address
sfrwe  in  1  SFR write strobe
sfrdatao  out  8  SFR read data
clkcpu  out  1  gated CPU clock
clkper  out  1  gated peripheral clock
rsto  out  1  internal reset driver
mempsrdrst  out  1  program-memory read reset
stoppmu  out  1  high in STOP or WARM
pmu_state  out  2  0=RUN 1=IDLE 2=STOP 3=WARM

Behaviour:
- Registers and async reset:
  - Everything except the reset generator is async-reset by rst.
  - Reset values: state=RUN, WAKEEN=8'h00, cpu_gate=1, per_gate=1, pmu_state=0, stoppmu=0, sfrdatao=0.
- Register fields:
  - PCON bit0 IDL and bit1 STP are write-1 triggers, not stored, and read as 0.
  - PCON bits 7:2 are read/write storage with reset value 0.
  - WAKEEN bits [NUM_WAKE-1:0] are read/write; unused upper bits read 0.
- sfrdatao: combinational mux on sfraddr; outputs 0 for other addresses.
- wake = intreq | |(wake_req & WAKEEN[NUM_WAKE-1:0]); the wake term is registered once (1-cycle latency).
- FSM, registered on posedge clk:
  - RUN -> STOP when a PCON write has STP=1. STP has priority over IDL.
  - RUN -> IDLE when a PCON write has IDL=1 and STP=0.
  - Either entry is suppressed (stay in RUN) if registered wake=1 in the write cycle.
  - IDLE -> RUN on registered wake.
  - STOP -> WARM on registered wake; the settle counter loads WAKE_DLY-1.
  - WARM: counter decrements each cycle; WARM -> RUN on the cycle the counter is 0. Wake is ignored in WARM.
  - A rst assertion in any state forces RUN immediately (async).
- Clock gates:
  - Registered on negedge clk, glitch-free.
  - cpu_gate = (next state == RUN).
  - per_gate = (next state is RUN or IDLE).
  - clkcpu = clk & (cpu_gate | scan_mode); clkper = clk & (per_gate | scan_mode).
- Reset generator (posedge clk; flops async-set by reset):
  - Cause = synchronised reset (2-flop) | wdts rising edge.
  - While the cause is active, stretch counter = RST_STRETCH; otherwise it decrements to 0.
  - rst_o = (cause active) | (counter != 0).
  - A new cause during stretching reloads the counter.
  - mempsrdrst = rst_o.
  - rsto = rst_o re-registered on negedge clk, so it reaches gated-clock domains.
  - In scan_mode: rsto = reset.
- Watchdog: wdts edge detection uses a wdts_ff reset by rst, so a wdts held high produces one stretch only.

Optional Feature:
Macro PMU_WAKE_STATUS_EN.
- Defined:
  - An 8-bit WAKESTAT register reads at WAKEEN_ADDR+1.
  - On each IDLE->RUN or STOP->WARM transition it captures the {intreq, masked wake_req} snapshot (intreq in bit NUM_WAKE, if NUM_WAKE<8).
  - It clears on a write of any value; reset value 0.
- Undefined: the register does not exist, and that address reads 0.

Test Plan:
1. Reset: reset=1 for 3 cycles then 0 -> rsto high through the hold plus RST_STRETCH=8 cycles; pmu_state=0; clkcpu and clkper toggle.
2. Idle: write PCON=8'h01, then assert wake_req[2] with WAKEEN=8'h04 -> pmu_state=1 and clkcpu stops; 1 cycle after the registered wake, back to RUN and clkcpu restarts while clkper never stops.
3. Stop: write PCON=8'h03, then raise intreq -> STOP (stoppmu=1, both clocks off); then WARM for exactly 16 cycles, then RUN.
4. Masked wake: WAKEEN=0, wake_req=4'hF in IDLE -> stays in IDLE; WAKEEN write 8'h01 -> RUN next cycle plus 1.
5. Suppressed entry: wake pending during a PCON=8'h02 write -> pmu_state stays 0 and the clocks never gate.
6. Watchdog: wdts 0->1 and held -> exactly one rsto pulse of 1+8 cycles; async rst during WARM -> pmu_state=0 immediately.
